// File: rtl/fp_ctrl_pkg.sv
// Shared state encoding, ALU opcodes and registered control bundle
// for the floating-point datapath sequencer.
package fp_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        EXP,
        ALIGN,
        MANT,
        NORM,
        DONE
    } state_t;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_MUL  = 4'b0001;
    localparam logic [3:0] ALU_ADDE = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0011;

    localparam logic [7:0] SHIFT_SAT     = 8'd25;
    localparam logic [4:0] NORM_MAX_STEP = 5'd15;

    typedef struct packed {
        logic               mux01;
        logic               mux02;
        logic               mux03;
        logic               mux04;
        logic               mux05;
        logic               mux06;
        logic [7:0]         shr;
        logic [3:0]         incdec;
        logic               incdec_en;
        logic signed [22:0] shlr;
        logic               mux_a;
        logic               mux_b;
        logic               mux_big;
        logic               sum_or_mul;
        logic               load_a;
        logic               load_b;
        logic [3:0]         big_op;
        logic [3:0]         small_op;
        logic               mux_a_small;
        logic               mux_b_small;
        logic               load_small;
        logic               busy;
        logic               done;
    } ctrl_t;

endpackage

// File: rtl/fp_control_unit_norm.sv
// One normalization pass: picks shift/exponent adjust for the current
// residue and flags whether another pass is still needed.
module fp_norm_step
    import fp_ctrl_pkg::*;
(
    input  logic               ovf_i,
    input  logic               zero_i,
    input  logic [4:0]         amt_i,
    output logic signed [22:0] shift_o,
    output logic [3:0]         adj_o,
    output logic               en_o,
    output logic               rep_o,
    output logic [4:0]         res_o
);

    logic [3:0] step;

    always_comb begin
        shift_o = '0;
        adj_o   = '0;
        en_o    = 1'b0;
        rep_o   = 1'b0;
        res_o   = '0;
        step    = '0;
        if (zero_i) begin
            step = '0;
        end else if (ovf_i) begin
            shift_o = -23'sd1;
            adj_o   = 4'd1;
            en_o    = 1'b1;
        end else begin
            // Exponent adjust field is 4 bits, so cap each pass at 15.
            if (amt_i > NORM_MAX_STEP) begin
                step  = 4'd15;
                rep_o = 1'b1;
                res_o = amt_i - NORM_MAX_STEP;
            end else begin
                step = amt_i[3:0];
            end
            shift_o = $signed({19'd0, step});
            adj_o   = step;
            en_o    = (step != 4'd0);
        end
    end

endmodule

// File: rtl/fp_control_unit.sv
// Sequencer for the single-precision FP datapath: drives every datapath
// control from a registered, state-decoded bundle.
module fp_control_unit
    import fp_ctrl_pkg::*;
#(
    parameter int EXP_W      = 8,
    parameter int CNT_W      = 4,
    parameter int MUL_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               op,
    input  logic [EXP_W-1:0]   expDiff,
    input  logic               mantOverflow,
    input  logic [4:0]         leadingZeros,
    input  logic               resultZero,
    output logic               controlToMux01,
    output logic               controlToMux02,
    output logic               controlToMux03,
    output logic               controlToMux04,
    output logic               controlToMux05,
    output logic               controlToMux06,
    output logic [7:0]         controlShiftRight,
    output logic [3:0]         controlToIncreaseOrDecrease,
    output logic               IncreaseOrDecreaseEnable,
    output logic signed [22:0] controlShiftLeftOrRight,
    output logic               muxAControl,
    output logic               muxBControl,
    output logic               muxControl,
    output logic               sumOrMultiplication,
    output logic               loadRegA,
    output logic               loadRegB,
    output logic [3:0]         bigALUOperation,
    output logic [3:0]         smallALUOperation,
    output logic               muxAControlSmall,
    output logic               muxBControlSmall,
    output logic               loadRegSmall,
    output logic               busy,
    output logic               done
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 1);

    state_t           state_q, state_d;
    logic             op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       res_q, res_d;
    logic             first_q, first_d;
    ctrl_t            out_q, out_d;

    logic signed [EXP_W:0] exp_ext;
    logic [EXP_W:0]        exp_abs;

    logic               n_ovf;
    logic               n_zero;
    logic [4:0]         n_amt;
    logic signed [22:0] n_shift;
    logic [3:0]         n_adj;
    logic               n_en;
    logic               n_rep;
    logic [4:0]         n_res;

    assign exp_ext = {expDiff[EXP_W-1], expDiff};
    assign exp_abs = exp_ext[EXP_W] ? $unsigned(-exp_ext)
                                    : $unsigned(exp_ext);

    // Later passes only burn down the leftover leading-zero residue.
    assign n_ovf  = first_q & mantOverflow;
    assign n_zero = first_q & resultZero;
    assign n_amt  = first_q ? leadingZeros : res_q;

    fp_norm_step u_norm (
        .ovf_i   (n_ovf),
        .zero_i  (n_zero),
        .amt_i   (n_amt),
        .shift_o (n_shift),
        .adj_o   (n_adj),
        .en_o    (n_en),
        .rep_o   (n_rep),
        .res_o   (n_res)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        first_d = first_q;
        out_d   = '0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = op;
                    state_d = EXP;
                end
            end
            EXP: begin
                out_d.load_small  = 1'b1;
                out_d.mux_a_small = 1'b0;
                out_d.mux_b_small = 1'b0;
                out_d.small_op    = op_q ? ALU_ADDE : ALU_SUB;
                if (op_q) begin
                    state_d = MANT;
                    cnt_d   = CNT_LOAD;
                end else begin
                    state_d = ALIGN;
                end
            end
            ALIGN: begin
                out_d.mux01 = 1'b1;
                out_d.mux04 = ~expDiff[EXP_W-1];
                if (exp_abs > (EXP_W+1)'(24)) begin
                    out_d.shr = SHIFT_SAT;
                end else begin
                    out_d.shr = 8'(exp_abs);
                end
                state_d = MANT;
                cnt_d   = '0;
            end
            MANT: begin
                out_d.mux_a      = 1'b1;
                out_d.mux_big    = 1'b1;
                out_d.sum_or_mul = ~op_q;
                out_d.big_op     = op_q ? ALU_MUL : ALU_ADD;
                if (!op_q || cnt_q == CNT_LOAD) begin
                    out_d.load_a = 1'b1;
                    out_d.load_b = 1'b1;
                end
                if (op_q && cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = NORM;
                    first_d = 1'b1;
                end
            end
            NORM: begin
                out_d.shlr      = n_shift;
                out_d.incdec    = n_adj;
                out_d.incdec_en = n_en;
                if (n_rep) begin
                    res_d   = n_res;
                    first_d = 1'b0;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_d.done  = 1'b1;
                out_d.mux06 = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        out_d.busy = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            first_q <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            first_q <= first_d;
            out_q   <= out_d;
        end
    end

    assign controlToMux01              = out_q.mux01;
    assign controlToMux02              = out_q.mux02;
    assign controlToMux03              = out_q.mux03;
    assign controlToMux04              = out_q.mux04;
    assign controlToMux05              = out_q.mux05;
    assign controlToMux06              = out_q.mux06;
    assign controlShiftRight           = out_q.shr;
    assign controlToIncreaseOrDecrease = out_q.incdec;
    assign IncreaseOrDecreaseEnable    = out_q.incdec_en;
    assign controlShiftLeftOrRight     = out_q.shlr;
    assign muxAControl                 = out_q.mux_a;
    assign muxBControl                 = out_q.mux_b;
    assign muxControl                  = out_q.mux_big;
    assign sumOrMultiplication         = out_q.sum_or_mul;
    assign loadRegA                    = out_q.load_a;
    assign loadRegB                    = out_q.load_b;
    assign bigALUOperation             = out_q.big_op;
    assign smallALUOperation           = out_q.small_op;
    assign muxAControlSmall            = out_q.mux_a_small;
    assign muxBControlSmall            = out_q.mux_b_small;
    assign loadRegSmall                = out_q.load_small;
    assign busy                        = out_q.busy;
    assign done                        = out_q.done;

endmodule

// File: doc/fp_control_unit.md
# fp_control_unit

Sequencing FSM for the single-precision floating-point datapath (`floating_point`); sits directly upstream and drives every control input the datapath exposes. It replaces hand-driven control vectors.
- Add: sequences exponent compare, mantissa alignment, big-ALU add and normalization.
- Multiply: sequences exponent add, mantissa multiply and normalization.
- Completion: asserts `done` for one cycle when the result is valid.

## Interface
- `EXP_W`, default 8: exponent/shift-amount width.
- `CNT_W`, default 4: multiply-wait counter width.
- `MUL_CYCLES`, default 4: cycles the big ALU needs for a mantissa multiply.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: begin operation; sampled only in IDLE.
- `op` in 1: 0 = add, 1 = multiply; latched on accepted `start`.
- `expDiff` in EXP_W: signed small-ALU result (exp1 − exp2), valid in ALIGN.
- `mantOverflow` in 1: big-ALU mantissa result ≥ 2.0.
- `leadingZeros` in 5: leading-zero count of the big-ALU mantissa result.
- `resultZero` in 1: big-ALU mantissa result is zero.
- `controlToMux01`..`controlToMux06` out 1 each: datapath mux selects.
- `controlShiftRight` out 8: alignment right-shift amount.
- `controlToIncreaseOrDecrease` out 4: exponent adjust amount.
- `IncreaseOrDecreaseEnable` out 1: apply exponent adjust.
- `controlShiftLeftOrRight` out 23 signed: normalize shift; positive = left, negative = right.
- `muxAControl`, `muxBControl`, `muxControl`, `sumOrMultiplication`, `loadRegA`, `loadRegB` out 1 each: big-ALU controls.
- `bigALUOperation` out 4: big-ALU opcode.
- `smallALUOperation` out 4: small-ALU opcode.
- `muxAControlSmall`, `muxBControlSmall`, `loadRegSmall` out 1 each: small-ALU controls.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.

## Operation
- **Reset.** All outputs are 0, including the multi-bit fields; the state is IDLE.
- **Registered outputs.** All outputs are registered and decoded from the state. Fields a state does not name are held at 0.
- **IDLE.** Stays here until `start`=1. On `start`, latch `op` and go to EXP.
- **EXP.** Sets `loadRegSmall`=1, `muxAControlSmall`=0, `muxBControlSmall`=0.
  - `smallALUOperation` = 4'b0011 (subtract) when op=0, 4'b0010 (add) when op=1.
  - Next state: ALIGN when op=0, MANT when op=1.
- **ALIGN (add only).** Sets `controlToMux01`=1 and `controlShiftRight` = |expDiff|.
  - `controlToMux04` = 1 when expDiff ≥ 0 (shift operand 2), 0 otherwise (shift operand 1).
  - If |expDiff| > 24, `controlShiftRight` saturates to 8'd25 (operand flushes to zero).
  - Next state: MANT.
- **MANT.** Sets `loadRegA`=`loadRegB`=1, `muxAControl`=1, `muxControl`=1.
  - `sumOrMultiplication` = ~op; `bigALUOperation` = 4'b0000 (add) or 4'b0001 (multiply).
  - Add: one cycle, then NORM.
  - Multiply: a counter loads MUL_CYCLES−1 on entry and decrements each cycle. Only the first MANT cycle pulses the loads; the state exits to NORM when the counter reaches 0.
- **NORM.**
  - If `resultZero`: no shift, no exponent adjust.
  - If `mantOverflow`: `controlShiftLeftOrRight` = −1, `controlToIncreaseOrDecrease` = 4'd1, `IncreaseOrDecreaseEnable`=1.
  - Otherwise: shift left by `leadingZeros` and decrement the exponent by `leadingZeros` (`controlToIncreaseOrDecrease` carries the low 4 bits).
  - If `leadingZeros` > 15, NORM repeats: each pass shifts and decrements by at most 15 until the residue is 0.
  - Next state: DONE.
- **DONE.** Sets `done`=1 and `controlToMux06`=1 (result register select). Returns to IDLE.
- **Start handling.** `start` while busy is ignored.
- **Reset mid-operation.** Returns to IDLE with all outputs 0 on the next edge; no `done` pulse.

## Timing
- Add latency: 5 cycles from `start` sampled to the `done` rising edge (EXP, ALIGN, MANT, NORM, DONE).
- Multiply latency: 3 + MUL_CYCLES cycles.
- Each extra NORM pass adds 1 cycle.
- `start` may be reasserted in the same cycle `done` is high; it is accepted in the following IDLE cycle.
- Status inputs are sampled only in their consuming state (`expDiff` in ALIGN; `mantOverflow`, `leadingZeros`, `resultZero` in NORM).

## Structure
- Package `fp_ctrl_pkg` holds:
  - the state enum (IDLE, EXP, ALIGN, MANT, NORM, DONE);
  - ALU opcode constants (ALU_ADD=4'b0000, ALU_MUL=4'b0001, ALU_ADDE=4'b0010, ALU_SUB=4'b0011);
  - SHIFT_SAT=8'd25.
- One sub-module: `fp_norm_step`. It is combinational and maps {`mantOverflow`, `leadingZeros`, residue} to the shift, adjust and repeat flag. The top holds the FSM, the counter and the output registers.

## Test plan
- **Add, 0.75 + 2.25.** Reset, `start`, op=0, expDiff=−2, NORM inputs all 0 → ALIGN: `controlShiftRight`=2, `controlToMux04`=0; `done` 5 cycles after `start`.
- **Add, large exponent gap.** expDiff=+40 → `controlShiftRight`=25, `controlToMux04`=1.
- **Multiply.** MUL_CYCLES=4, op=1 → `loadRegA`/`loadRegB` high for 1 cycle only; `sumOrMultiplication`=0; `done` at cycle 7.
- **Normalize.**
  - `mantOverflow`=1 → `controlShiftLeftOrRight`=−1, `controlToIncreaseOrDecrease`=1, enable=1.
  - `leadingZeros`=20 → two NORM cycles (15, then 5); add latency becomes 6.
- **Reset mid-operation.** `reset` asserted in MANT → next cycle all outputs 0, `busy`=0, no `done`; a new `start` completes normally.
- **Start while busy.** `start` held high through an operation → exactly one `done` per accepted start; a back-to-back start is accepted the cycle after `done`.
